// File: rtl/noc_packetizer_if.sv
// noc_packetizer_if: request, data-word and flit channels of the packetizer.
interface noc_packetizer_if #(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int MESH_ADDR_X     = 4,
   parameter int MESH_ADDR_Y     = 4,
   parameter int LEN_WIDTH       = 16
);
   logic                         req_valid;
   logic                         req_ready;
   logic [MESH_ADDR_X-1:0]       req_dst_x;
   logic [MESH_ADDR_Y-1:0]       req_dst_y;
   logic [LEN_WIDTH-1:0]         req_len_bits;
   logic                         in_valid;
   logic                         in_ready;
   logic [FLIT_DATA_WIDTH-1:0]   in_data;
   logic                         flit_valid;
   logic                         flit_ready;
   logic [FLIT_DATA_WIDTH+1:0]   flit;

   modport master (
      output req_valid, req_dst_x, req_dst_y, req_len_bits, in_valid, in_data, flit_ready,
      input  req_ready, in_ready, flit_valid, flit
   );
   modport slave (
      input  req_valid, req_dst_x, req_dst_y, req_len_bits, in_valid, in_data, flit_ready,
      output req_ready, in_ready, flit_valid, flit
   );
endinterface

// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a message request plus 32-bit data words into a HEADER/DATA.../TAIL flit stream.
module noc_packetizer #(
   parameter int FLIT_DATA_WIDTH        = 32,
   parameter int MESH_ADDR_X            = 4,
   parameter int MESH_ADDR_Y            = 4,
   parameter int FLIT_TAIL_LENGTH_WIDTH = 5,
   parameter int LEN_WIDTH              = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   noc_packetizer_if.slave     bus,
   output logic                busy,
   output logic                err_len
);
   localparam int TLW = FLIT_TAIL_LENGTH_WIDTH;
   localparam int CW  = LEN_WIDTH - TLW + 1;
   localparam logic [1:0] HEADER = 2'd0, DATA = 2'd1, TAIL = 2'd2;

   typedef enum logic {IDLE, BODY} state_t;

   state_t                     state;
   logic [CW-1:0]              cnt;
   logic [TLW-1:0]             tail_len;
   logic                       slot_free, req_hs, in_hs;
   logic [CW-1:0]              words;
   logic [FLIT_DATA_WIDTH-1:0] hdr, mask;

   assign slot_free     = !bus.flit_valid || bus.flit_ready;
   assign bus.req_ready = (state == IDLE) && slot_free;
   assign bus.in_ready  = (state == BODY) && slot_free;
   assign req_hs        = bus.req_valid && bus.req_ready;
   assign in_hs         = bus.in_valid && bus.in_ready;
   assign busy          = state == BODY;
   assign words         = CW'(bus.req_len_bits[LEN_WIDTH-1:TLW]) + CW'(|bus.req_len_bits[TLW-1:0]);
   assign hdr           = FLIT_DATA_WIDTH'({bus.req_dst_x, bus.req_dst_y, bus.req_len_bits[TLW-1:0]});
   // a zero tail_length means the last word is fully populated
   assign mask          = tail_len == '0 ? '1 : (FLIT_DATA_WIDTH'(1) << tail_len) - FLIT_DATA_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.flit_valid <= 1'b0;
         bus.flit       <= '0;
         cnt            <= '0;
         tail_len       <= '0;
         err_len        <= 1'b0;
      end else begin
         err_len <= 1'b0;
         if (state == IDLE) begin
            if (req_hs && bus.req_len_bits != '0) begin
               bus.flit       <= {HEADER, hdr};
               bus.flit_valid <= 1'b1;
               cnt            <= words;
               tail_len       <= bus.req_len_bits[TLW-1:0];
               state          <= BODY;
            end else begin
               err_len <= req_hs;
               if (slot_free) bus.flit_valid <= 1'b0;
            end
         end else if (in_hs) begin
            bus.flit_valid <= 1'b1;
            cnt            <= cnt - CW'(1);
            bus.flit       <= cnt == CW'(1) ? {TAIL, bus.in_data & mask} : {DATA, bus.in_data};
            if (cnt == CW'(1)) state <= IDLE;
         end else if (slot_free) begin
            bus.flit_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: directed vectors with hand-computed flits for noc_packetizer.
module tb_noc_packetizer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, err_len;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] wd [4];
   logic [33:0] ex [5];

   noc_packetizer_if bus ();

   noc_packetizer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_len(err_len));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ex[0] is the header, ex[1..n] the flits produced from wd[0..n-1]
   task automatic run_msg(input logic [3:0] x, input logic [3:0] y, input logic [15:0] l,
                          input int n, input bit stall);
      bus.req_valid = 1'b1; bus.req_dst_x = x; bus.req_dst_y = y; bus.req_len_bits = l;
      bus.in_valid = 1'b0; bus.flit_ready = 1'b1;
      #1 chk("req_ready_idle", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      chk("hdr_valid", bus.flit_valid, 1);
      chk("hdr_flit", bus.flit, ex[0]);
      chk("busy_body", busy, 1);
      if (stall) begin
         bus.flit_ready = 1'b0;
         bus.in_valid = 1'b1; bus.in_data = wd[0];
         for (int s = 0; s < 3; s++) begin
            #1 chk("stall_in_ready", bus.in_ready, 0);
            tick();
            chk("stall_hold_valid", bus.flit_valid, 1);
            chk("stall_hold_flit", bus.flit, ex[0]);
         end
         bus.flit_ready = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1; bus.in_data = wd[i];
         #1 chk("in_ready_body", bus.in_ready, 1);
         chk("req_ready_body", bus.req_ready, 0);
         tick();
         chk("body_valid", bus.flit_valid, 1);
         chk("body_flit", bus.flit, ex[i+1]);
      end
      bus.in_valid = 1'b0;
      chk("busy_after_tail", busy, 0);
      tick();
      chk("drain_valid", bus.flit_valid, 0);
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_dst_x = '0; bus.req_dst_y = '0; bus.req_len_bits = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.flit_ready = 1'b1;
      #12;
      chk("rst_flit_valid", bus.flit_valid, 0);
      chk("rst_flit", bus.flit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      rst_n = 1'b1;
      tick();

      wd[0] = 32'hDEADBEEF;
      ex[0] = 34'h0_000006A0; ex[1] = 34'h2_DEADBEEF;
      run_msg(4'd3, 4'd5, 16'd32, 1, 1'b0);

      wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'hFFFFFFFF;
      ex[0] = 34'h0_00000248; ex[1] = 34'h1_11111111; ex[2] = 34'h1_22222222; ex[3] = 34'h2_000000FF;
      run_msg(4'd1, 4'd2, 16'd72, 3, 1'b0);
      run_msg(4'd1, 4'd2, 16'd72, 3, 1'b1);

      // back-to-back: L=32 to (1,1), then L=40 to (2,1), req_valid held
      bus.req_valid = 1'b1; bus.req_dst_x = 4'd1; bus.req_dst_y = 4'd1; bus.req_len_bits = 16'd32;
      bus.in_valid = 1'b1; bus.in_data = 32'hA5A5A5A5; bus.flit_ready = 1'b1;
      tick();
      chk("b2b_h1", bus.flit, 34'h0_00000220);
      bus.req_dst_x = 4'd2; bus.req_len_bits = 16'd40;
      tick();
      chk("b2b_t1", bus.flit, 34'h2_A5A5A5A5);
      chk("b2b_t1_valid", bus.flit_valid, 1);
      bus.in_data = 32'h12345678;
      #1 chk("b2b_req_ready", bus.req_ready, 1);
      chk("b2b_in_ready_idle", bus.in_ready, 0);
      tick();
      chk("b2b_h2", bus.flit, 34'h0_00000428);
      bus.req_valid = 1'b0;
      tick();
      chk("b2b_d2", bus.flit, 34'h1_12345678);
      bus.in_data = 32'hCAFEBABE;
      tick();
      chk("b2b_t2", bus.flit, 34'h2_000000BE);
      chk("b2b_t2_valid", bus.flit_valid, 1);
      bus.in_valid = 1'b0;
      tick();
      chk("b2b_drain", bus.flit_valid, 0);

      // zero-length request is dropped with a single err_len pulse
      bus.req_valid = 1'b1; bus.req_len_bits = 16'd0;
      #1 chk("zero_req_ready", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      chk("zero_err_len", err_len, 1);
      chk("zero_no_flit", bus.flit_valid, 0);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_err_clear", err_len, 0);
      chk("zero_still_no_flit", bus.flit_valid, 0);
      chk("zero_idle", bus.req_ready, 1);

      // reset mid-message after one DATA flit of an L=96 message
      bus.req_valid = 1'b1; bus.req_dst_x = 4'd4; bus.req_dst_y = 4'd4; bus.req_len_bits = 16'd96;
      tick();
      bus.req_valid = 1'b0;
      chk("rst_msg_hdr", bus.flit, 34'h0_00000880);
      bus.in_valid = 1'b1; bus.in_data = 32'h01020304;
      tick();
      chk("rst_msg_data", bus.flit, 34'h1_01020304);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.flit_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_flit", bus.flit, 0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_valid", bus.flit_valid, 0);
      wd[0] = 32'hDEADBEEF;
      ex[0] = 34'h0_000006A0; ex[1] = 34'h2_DEADBEEF;
      run_msg(4'd3, 4'd5, 16'd32, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Source-side network-interface stage: turns a message request (destination, bit length) plus a stream of 32-bit data words into a flit stream for the router local input port.
- Flit sequence per message: one HEADER, (W-1) DATA, one TAIL.
- Flit format: type[1:0] concatenated above payload; HEADER=0, DATA=1, TAIL=2, 3 reserved and never emitted.

Parameters:
- FLIT_DATA_WIDTH, 32, flit payload width and input word width
- MESH_ADDR_X, 4, destination X address width
- MESH_ADDR_Y, 4, destination Y address width
- FLIT_TAIL_LENGTH_WIDTH, 5, header tail_length field width (log2 FLIT_DATA_WIDTH)
- LEN_WIDTH, 16, message length field width (bits)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  message request valid
- req_ready  out  1  request accepted when req_valid and req_ready both high
- req_dst_x  in  MESH_ADDR_X  destination X
- req_dst_y  in  MESH_ADDR_Y  destination Y
- req_len_bits  in  LEN_WIDTH  message length in bits
- in_valid  in  1  data word valid
- in_ready  out  1  data word accepted when in_valid and in_ready both high
- in_data  in  FLIT_DATA_WIDTH  data word, LSB-first bit order
- flit_valid  out  1  output flit valid
- flit_ready  in  1  downstream accepts flit
- flit  out  FLIT_DATA_WIDTH+2  {type, payload}
- busy  out  1  high while in BODY state
- err_len  out  1  one-cycle pulse when a zero-length request is dropped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; flit_valid=0; flit=0; busy=0; err_len=0; word counter=0.
  - A message in progress is abandoned and no TAIL is emitted.
- Output register: a single stage. "Slot free" means (!flit_valid || flit_ready).
  - flit and flit_valid must stay stable while flit_valid=1 and flit_ready=0.
- W = ceil(L/32), computed as L[LEN_WIDTH-1:5] + |L[4:0].
- tail_length = L[4:0]; the value 0 encodes a full 32-bit tail.
- Header payload, zero-extended to FLIT_DATA_WIDTH:
  - x at [12:9], y at [8:5], tail_length at [4:0]
  - bits [31:13] are 0.
- State IDLE:
  - req_ready = slot free; in_ready = 0.
  - On a request handshake with L≠0: flit <= {HEADER, hdr_payload}, flit_valid <= 1, counter <= W, latch tail_length, go to BODY.
  - On a request handshake with L=0: request consumed, no flit, err_len=1 for exactly one cycle, stay in IDLE.
  - If the slot is free and there is no handshake: flit_valid <= 0.
- State BODY:
  - req_ready = 0; in_ready = slot free; busy = 1.
  - On a data handshake with counter>1: flit <= {DATA, in_data}; counter decrements.
  - On a data handshake with counter==1:
    - flit <= {TAIL, in_data AND mask}.
    - mask = all-ones if tail_length==0, else (1<<tail_length)-1.
    - Go to IDLE.
  - If the slot is free and there is no handshake: flit_valid <= 0.
- Latency: an accepted request or word appears on flit the next cycle.
- Throughput: 1 flit/cycle sustained, including header-after-tail.
- Back-to-back messages: a request may handshake in the first IDLE cycle after the TAIL is loaded, provided the slot is free; there is no bubble between a TAIL and the next HEADER.
- Handshake/combinational rules:
  - in_ready and req_ready are never high in the same cycle.
  - No combinational path from in_valid or req_valid to any ready.
  - A combinational path from flit_ready to req_ready/in_ready is allowed.
- Data words presented while in IDLE are not accepted (in_ready=0).

Test Plan:
- L=32, dst(3,5), word 0xDEADBEEF, flit_ready=1 -> HEADER flit 34'h0_000006A0, next cycle TAIL 34'h2_DEADBEEF, then flit_valid=0, busy=0.
- L=72, dst(1,2), words 0x11111111, 0x22222222, 0xFFFFFFFF -> flits 34'h0_00000248, 34'h1_11111111, 34'h1_22222222, 34'h2_000000FF on consecutive cycles.
- Same as the L=72 case, with flit_ready low for 3 cycles after the HEADER appears -> HEADER held stable, in_ready=0 for those 3 cycles, no word lost, identical flit sequence afterwards.
- Two messages, L=32 then L=40, with req_valid held and flit_ready=1 -> 5 flits on 5 consecutive cycles (H,T,H,D,T); second tail payload masked to 8 bits.
- req_len_bits=0 -> err_len high for exactly one cycle, req_ready handshake completes, no flit emitted, state stays IDLE.
- rst_n asserted after 1 DATA flit of an L=96 message, then released -> flit_valid=0 immediately, busy=0; next L=32 request produces a normal HEADER+TAIL.
